// File: rtl/xram_port_scheduler.sv
// Two-port request scheduler for a true dual-port RAM: serializes same-address
// write collisions, registers the RAM port signals and tags read returns.
module xram_port_scheduler #(
    parameter int unsigned ADDRESS_WIDTH = 10,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned COUNT_WIDTH   = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valid_a,
    input  logic                     req_valid_b,
    output logic                     req_ready_a,
    output logic                     req_ready_b,
    input  logic                     req_write_a,
    input  logic                     req_write_b,
    input  logic [ADDRESS_WIDTH-1:0] req_address_a,
    input  logic [ADDRESS_WIDTH-1:0] req_address_b,
    input  logic [DATA_WIDTH-1:0]    req_data_a,
    input  logic [DATA_WIDTH-1:0]    req_data_b,
    output logic [ADDRESS_WIDTH-1:0] address_a,
    output logic [ADDRESS_WIDTH-1:0] address_b,
    output logic [DATA_WIDTH-1:0]    data_a,
    output logic [DATA_WIDTH-1:0]    data_b,
    output logic                     write_enable_a,
    output logic                     write_enable_b,
    output logic                     read_enable_a,
    output logic                     read_enable_b,
    input  logic [DATA_WIDTH-1:0]    q_a,
    input  logic [DATA_WIDTH-1:0]    q_b,
    output logic [DATA_WIDTH-1:0]    rdata_a,
    output logic [DATA_WIDTH-1:0]    rdata_b,
    output logic                     rvalid_a,
    output logic                     rvalid_b,
    output logic [COUNT_WIDTH-1:0]   collision_count
);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

    prio_e                    prio_q, prio_d;
    logic                     collision;
    logic                     accept_a, accept_b;

    logic [ADDRESS_WIDTH-1:0] address_a_q, address_a_d, address_b_q, address_b_d;
    logic [DATA_WIDTH-1:0]    data_a_q, data_a_d, data_b_q, data_b_d;
    logic                     we_a_q, we_a_d, we_b_q, we_b_d;
    logic                     re_a_q, re_a_d, re_b_q, re_b_d;
    logic [READ_LATENCY-1:0]  pipe_a_q, pipe_a_d, pipe_b_q, pipe_b_d;
    logic [READ_LATENCY:0]    chain_a, chain_b;
    logic [DATA_WIDTH-1:0]    hold_a_q, hold_a_d, hold_b_q, hold_b_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;

    always_comb begin
        collision   = req_valid_a & req_valid_b & (req_address_a == req_address_b)
                      & (req_write_a | req_write_b);
        req_ready_a = ~collision | (prio_q == PRIO_A);
        req_ready_b = ~collision | (prio_q == PRIO_B);
        accept_a    = req_valid_a & req_ready_a;
        accept_b    = req_valid_b & req_ready_b;

        // The loser of a collision owns priority for the next collision.
        prio_d = prio_q;
        if (collision) begin
            prio_d = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
        end

        address_a_d = accept_a ? req_address_a : address_a_q;
        data_a_d    = accept_a ? req_data_a    : data_a_q;
        we_a_d      = accept_a &  req_write_a;
        re_a_d      = accept_a & ~req_write_a;
        address_b_d = accept_b ? req_address_b : address_b_q;
        data_b_d    = accept_b ? req_data_b    : data_b_q;
        we_b_d      = accept_b &  req_write_b;
        re_b_d      = accept_b & ~req_write_b;

        // Concatenate so the shift works for any depth, including 1.
        chain_a  = {pipe_a_q, re_a_q};
        chain_b  = {pipe_b_q, re_b_q};
        pipe_a_d = chain_a[READ_LATENCY-1:0];
        pipe_b_d = chain_b[READ_LATENCY-1:0];

        hold_a_d = rvalid_a ? q_a : hold_a_q;
        hold_b_d = rvalid_b ? q_b : hold_b_q;

        count_d = count_q;
        if (collision && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio_q      <= PRIO_A;
            address_a_q <= '0;
            address_b_q <= '0;
            data_a_q    <= '0;
            data_b_q    <= '0;
            we_a_q      <= 1'b0;
            we_b_q      <= 1'b0;
            re_a_q      <= 1'b0;
            re_b_q      <= 1'b0;
            pipe_a_q    <= '0;
            pipe_b_q    <= '0;
            hold_a_q    <= '0;
            hold_b_q    <= '0;
            count_q     <= '0;
        end else begin
            prio_q      <= prio_d;
            address_a_q <= address_a_d;
            address_b_q <= address_b_d;
            data_a_q    <= data_a_d;
            data_b_q    <= data_b_d;
            we_a_q      <= we_a_d;
            we_b_q      <= we_b_d;
            re_a_q      <= re_a_d;
            re_b_q      <= re_b_d;
            pipe_a_q    <= pipe_a_d;
            pipe_b_q    <= pipe_b_d;
            hold_a_q    <= hold_a_d;
            hold_b_q    <= hold_b_d;
            count_q     <= count_d;
        end
    end

    assign address_a       = address_a_q;
    assign address_b       = address_b_q;
    assign data_a          = data_a_q;
    assign data_b          = data_b_q;
    assign write_enable_a  = we_a_q;
    assign write_enable_b  = we_b_q;
    assign read_enable_a   = re_a_q;
    assign read_enable_b   = re_b_q;
    assign rvalid_a        = pipe_a_q[READ_LATENCY-1];
    assign rvalid_b        = pipe_b_q[READ_LATENCY-1];
    // RAM output passes straight through while valid; otherwise the last return is held.
    assign rdata_a         = rvalid_a ? q_a : hold_a_q;
    assign rdata_b         = rvalid_b ? q_b : hold_b_q;
    assign collision_count = count_q;

endmodule

// File: doc/xram_port_scheduler.md
# xram_port_scheduler

Two-requester scheduler in front of a true dual-port Xilinx RAM (address 10 b, data 32 b). It accepts one request stream per RAM port and drives both ports on registered outputs. When requests collide (same address, at least one write), it serializes them so the RAM never sees a write collision. It tags read returns with a valid strobe aligned to the RAM read latency. It sits between the datapath requesters and the xram instance, and removes collision-mode dependence from simulation and hardware.

## Interface
Parameters:
- ADDRESS_WIDTH, 10, RAM address width
- DATA_WIDTH, 32, RAM data width
- READ_LATENCY, 1, cycles from a RAM read enable to valid RAM output; legal range 1..3
- COUNT_WIDTH, 16, width of the collision counter

Ports:
- clock  in  1  single clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid_a / req_valid_b  in  1  request present on port a / b
- req_ready_a / req_ready_b  out  1  request accepted this cycle when valid & ready
- req_write_a / req_write_b  in  1  1 = write, 0 = read
- req_address_a / req_address_b  in  ADDRESS_WIDTH  request address
- req_data_a / req_data_b  in  DATA_WIDTH  write data
- address_a / address_b  out  ADDRESS_WIDTH  to RAM, registered
- data_a / data_b  out  DATA_WIDTH  to RAM, registered
- write_enable_a / write_enable_b  out  1  to RAM, registered
- read_enable_a / read_enable_b  out  1  to RAM, registered
- q_a / q_b  in  DATA_WIDTH  RAM read data
- rdata_a / rdata_b  out  DATA_WIDTH  returned read data
- rvalid_a / rvalid_b  out  1  rdata valid strobe, one cycle per read
- collision_count  out  COUNT_WIDTH  saturating count of collision cycles

## Operation
- Collision: req_valid_a & req_valid_b & (req_address_a == req_address_b) & (req_write_a | req_write_b). A read-read to the same address is not a collision.
- Priority register prio (0 = a, 1 = b). Reset value is 0.
- No collision: req_ready_a = req_ready_b = 1. Ready is combinational from the valids, addresses and prio. Ready is 1 even when valid is 0.
- Collision: only the prio port is ready; the other port's ready is 0. prio flips to the losing port at the end of that cycle. prio is unchanged in cycles without a collision.
- Accepted request at cycle t: the RAM port registers load at edge t→t+1.
  - address = req_address, data = req_data.
  - write_enable = req_write, read_enable = ~req_write.
- With no acceptance on a port, both of that port's enables are 0 the next cycle. Address and data hold their last values.
- Per-port read pipeline: a READ_LATENCY-deep shift register of read_enable.
  - rvalid_x = tail of the shift register.
  - rdata_x = q_x sampled in the same cycle. It is the registered RAM output passed through, with no extra register.
  - rdata_x holds its last value when rvalid_x is 0.
- collision_count increments by 1 on each collision cycle and saturates at all-ones.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): all outputs are 0, prio = 0, read pipelines are cleared, and collision_count = 0.
- Reset mid-operation: in-flight reads are dropped and no rvalid is produced for them.
- Latency: request accepted at cycle t puts the RAM enable in t+1. Read data returns with rvalid in cycle t+1+READ_LATENCY.
- Throughput: one request per port per cycle when there is no collision.
- A persistent collision alternates grants a, b, a, b… Each requester is served at least every 2 cycles.
- Back-to-back reads on one port give contiguous rvalid cycles, in order.
- A write accepted at t and a read of the same address on the other port accepted at t+1 are not a collision. The read returns the new data.

## Test plan
- Reset, then idle:
  - After reset_n rises, all enables and rvalids are 0, collision_count = 0, and both readies are 1.
- Independent traffic:
  - Stimulus: a writes addr 3 = 0x0000_0008, b reads addr 5 in the same cycle.
  - Response: both accepted; write_enable_a = 1 and read_enable_b = 1 next cycle; rvalid_b after 1+READ_LATENCY cycles; collision_count = 0.
- Write/read collision:
  - Stimulus: a writes addr 1 = 8, b reads addr 1, both held valid.
  - Response: cycle 0 grants a only (ready_b = 0); cycle 1 grants b; rdata_b = 8; collision_count = 1.
- Write/write collision held 4 cycles:
  - Stimulus: a writes addr 2 = 18, b writes addr 2 = 19.
  - Response: grants alternate a, b, a, b; addr 2 finally holds 19 (read back by a); collision_count = 4.
- Read/read same address:
  - Stimulus: both read addr 0, pre-loaded with 0xFF.
  - Response: both ready, both rvalid in the same cycle, rdata_a = rdata_b = 0xFF; no collision counted.
- Reset mid-read and counter saturation:
  - Stimulus: assert reset_n low one cycle after a read is accepted.
  - Response: no rvalid ever appears for that read.
  - Stimulus: with COUNT_WIDTH = 2, drive 5 collision cycles.
  - Response: collision_count stays at 3.
